// File: rtl/yc_enc_ctrl.sv
// yc_enc_ctrl: video encoder control block.
// Double-buffered configuration (shadow registers applied atomically on a vsync
// rising edge after a commit) plus an hsync line-period tracker that
// acquires/holds line lock and clamps the colour-burst window to the line.
module yc_enc_ctrl #(
   parameter int TOL     = 2,
   parameter int TIMEOUT = 4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [39:0] cfg_data,
   output logic        cfg_ack,
   output logic        cfg_pending,
   output logic [39:0] PHASE_INC,
   output logic        PAL_EN,
   output logic        CVBS,
   output logic [16:0] COLORBURST_RANGE,
   output logic [11:0] line_len,
   output logic        locked,
   output logic        chroma_kill
);

   localparam logic [11:0]        C_TIMEOUT = 12'(TIMEOUT);
   localparam logic signed [12:0] C_TOL     = 13'(TOL);
   localparam logic [16:0]        C_RANGE_RST = {7'd40, 10'd240};

   typedef enum logic [1:0] {S_UNLOCK, S_ACQ, S_LOCK} state_t;

   // ---------------- configuration path ----------------
   logic        r_ack;
   logic        r_pending;
   logic        r_vsync_d;
   logic [39:0] r_sh_phase;
   logic        r_sh_pal;
   logic        r_sh_cvbs;
   logic [16:0] r_sh_range;
   logic [39:0] r_phase;
   logic        r_pal;
   logic        r_cvbs;
   logic [16:0] r_range;

   logic w_wr_phase;
   logic w_wr_mode;
   logic w_wr_range;
   logic w_wr_commit;
   logic w_vs_edge;
   logic w_apply;

   assign w_wr_phase  = cfg_we && (cfg_addr == 2'd0);
   assign w_wr_mode   = cfg_we && (cfg_addr == 2'd1);
   assign w_wr_range  = cfg_we && (cfg_addr == 2'd2);
   assign w_wr_commit = cfg_we && (cfg_addr == 2'd3);
   assign w_vs_edge   = vsync && !r_vsync_d;
   assign w_apply     = w_vs_edge && r_pending;

   // Shadow writes, commit arming and atomic shadow->active transfer. Active
   // registers copy the pre-edge shadow, so a same-cycle shadow write stays
   // in shadow only; a same-cycle commit re-arms for the following edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack      <= 1'b0;
         r_pending  <= 1'b0;
         r_vsync_d  <= 1'b0;
         r_sh_phase <= 40'h0;
         r_sh_pal   <= 1'b0;
         r_sh_cvbs  <= 1'b0;
         r_sh_range <= C_RANGE_RST;
         r_phase    <= 40'h0;
         r_pal      <= 1'b0;
         r_cvbs     <= 1'b0;
         r_range    <= C_RANGE_RST;
      end else begin
         r_ack     <= cfg_we;
         r_vsync_d <= vsync;
         if (w_wr_phase) r_sh_phase <= cfg_data;
         if (w_wr_mode) begin
            r_sh_pal  <= cfg_data[0];
            r_sh_cvbs <= cfg_data[1];
         end
         if (w_wr_range) r_sh_range <= cfg_data[16:0];
         if (w_apply) begin
            r_phase <= r_sh_phase;
            r_pal   <= r_sh_pal;
            r_cvbs  <= r_sh_cvbs;
            r_range <= r_sh_range;
         end
         if (w_wr_commit)  r_pending <= 1'b1;
         else if (w_apply) r_pending <= 1'b0;
      end
   end

   // ---------------- line timing path ----------------
   state_t      r_state;
   state_t      w_state_next;
   logic [11:0] r_cnt;
   logic        r_hsync_d;
   logic [11:0] r_ref;
   logic [11:0] w_ref_next;
   logic [1:0]  r_match;
   logic [1:0]  w_match_next;
   logic [11:0] r_line_len;
   logic [11:0] w_line_len_next;
   logic        r_locked;
   logic        w_locked_next;

   logic               w_hs_edge;
   logic [11:0]        w_period;
   logic [11:0]        w_cnt_next;
   logic               w_timeout;
   logic signed [12:0] w_diff_ref;
   logic signed [12:0] w_diff_len;
   logic signed [12:0] w_abs_ref;
   logic signed [12:0] w_abs_len;
   logic               w_ref_ok;
   logic               w_len_ok;

   assign w_hs_edge  = hsync && !r_hsync_d;
   assign w_period   = r_cnt + 12'd1;
   assign w_cnt_next = w_hs_edge ? 12'd0 :
                       (r_cnt < C_TIMEOUT) ? (r_cnt + 12'd1) : r_cnt;
   // An edge restarts the counter, so it always wins over a timeout.
   assign w_timeout  = !w_hs_edge && (w_cnt_next == C_TIMEOUT);

   // Differences are taken with a sign bit so they never wrap.
   assign w_diff_ref = $signed({1'b0, w_period}) - $signed({1'b0, r_ref});
   assign w_diff_len = $signed({1'b0, w_period}) - $signed({1'b0, r_line_len});
   assign w_abs_ref  = w_diff_ref[12] ? -w_diff_ref : w_diff_ref;
   assign w_abs_len  = w_diff_len[12] ? -w_diff_len : w_diff_len;
   assign w_ref_ok   = (w_abs_ref <= C_TOL);
   assign w_len_ok   = (w_abs_len <= C_TOL);

   // Lock state register, period counter and tracker registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_UNLOCK;
         r_cnt      <= 12'd0;
         r_hsync_d  <= 1'b0;
         r_ref      <= 12'd0;
         r_match    <= 2'd0;
         r_line_len <= 12'd0;
         r_locked   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_hsync_d  <= hsync;
         r_ref      <= w_ref_next;
         r_match    <= w_match_next;
         r_line_len <= w_line_len_next;
         r_locked   <= w_locked_next;
      end
   end

   // Next-state logic: acquire on two consecutive matching periods, drop to
   // ACQ on a bad period and to UNLOCK when hsync disappears.
   always_comb begin
      w_state_next    = r_state;
      w_ref_next      = r_ref;
      w_match_next    = r_match;
      w_line_len_next = r_line_len;
      w_locked_next   = r_locked;
      if (w_timeout) begin
         w_state_next  = S_UNLOCK;
         w_locked_next = 1'b0;
      end else if (w_hs_edge) begin
         case (r_state)
            S_UNLOCK: begin
               // First period after losing sync is unreliable and discarded.
               w_state_next = S_ACQ;
               w_ref_next   = 12'd0;
               w_match_next = 2'd0;
            end
            S_ACQ: begin
               if (w_ref_ok) begin
                  if (r_match == 2'd1) begin
                     w_state_next    = S_LOCK;
                     w_line_len_next = r_ref;
                     w_locked_next   = 1'b1;
                     w_match_next    = 2'd2;
                  end else begin
                     w_match_next = r_match + 2'd1;
                  end
               end else begin
                  w_ref_next   = w_period;
                  w_match_next = 2'd0;
               end
            end
            S_LOCK: begin
               if (!w_len_ok) begin
                  w_state_next  = S_ACQ;
                  w_ref_next    = w_period;
                  w_match_next  = 2'd0;
                  w_locked_next = 1'b0;
               end
            end
            default: begin
               w_state_next  = S_UNLOCK;
               w_locked_next = 1'b0;
            end
         endcase
      end
   end

   // Burst end never runs past the last clock of a locked line.
   logic [11:0] w_end_lim;
   logic        w_clamp;

   assign w_end_lim = r_line_len - 12'd1;
   assign w_clamp   = r_locked && ({2'b00, r_range[9:0]} > w_end_lim);

   assign cfg_ack          = r_ack;
   assign cfg_pending      = r_pending;
   assign PHASE_INC        = r_phase;
   assign PAL_EN           = r_pal;
   assign CVBS             = r_cvbs;
   assign COLORBURST_RANGE = {r_range[16:10], w_clamp ? w_end_lim[9:0] : r_range[9:0]};
   assign line_len         = r_line_len;
   assign locked           = r_locked;
   assign chroma_kill      = !r_locked;

endmodule

// File: tb/tb_yc_enc_ctrl.sv
// tb_yc_enc_ctrl: directed stimulus with a scoreboard. The stimulus pushes the
// expected output snapshot (and the cycle it must appear in) whenever it causes
// a change; the monitor pops one entry each time the outputs change or
// cfg_ack pulses, and compares both snapshot and cycle.
module tb_yc_enc_ctrl;

   localparam int TOL     = 2;
   localparam int TIMEOUT = 4000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [39:0] cfg_data = 40'h0;
   logic        cfg_ack;
   logic        cfg_pending;
   logic [39:0] PHASE_INC;
   logic        PAL_EN;
   logic        CVBS;
   logic [16:0] COLORBURST_RANGE;
   logic [11:0] line_len;
   logic        locked;
   logic        chroma_kill;

   yc_enc_ctrl #(.TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_ack(cfg_ack), .cfg_pending(cfg_pending), .PHASE_INC(PHASE_INC),
      .PAL_EN(PAL_EN), .CVBS(CVBS), .COLORBURST_RANGE(COLORBURST_RANGE),
      .line_len(line_len), .locked(locked), .chroma_kill(chroma_kill)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        ack;
      logic        pend;
      logic [39:0] phase;
      logic        pal;
      logic        cvbs;
      logic [16:0] range;
      logic [11:0] llen;
      logic        lock;
      logic        kill;
   } snap_t;

   snap_t m;
   snap_t q_snap[$];
   int    q_cyc[$];
   string q_tag[$];
   int    n_total = 0;
   int    n_bad = 0;
   bit    started = 1'b0;
   int    last_hs = 0;

   function automatic snap_t reset_snap();
      snap_t r;
      r       = '0;
      r.range = {7'd40, 10'd240};
      r.kill  = 1'b1;
      return r;
   endfunction

   task automatic push_at(input string tag, input int c);
      q_snap.push_back(m);
      q_cyc.push_back(c);
      q_tag.push_back(tag);
      m.ack = 1'b0;
   endtask

   task automatic push(input string tag);
      push_at(tag, cyc + 1);
   endtask

   task automatic tick();
      @(negedge clk);
      cfg_we = 1'b0;
      hsync  = 1'b0;
   endtask

   task automatic write(input logic [1:0] a, input logic [39:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      m.ack    = 1'b1;
   endtask

   task automatic hs_at(input int p);
      while (cyc < last_hs + p) tick();
      hsync   = 1'b1;
      last_hs = cyc;
   endtask

   // Monitor: one scoreboard pop per output change or ack pulse.
   initial begin : monitor
      snap_t s, prev, e, a, b;
      int    ec;
      string et;
      bit    first;
      first = 1'b1;
      prev  = '0;
      wait (started);
      forever begin
         @(negedge clk);
         s = {cfg_ack, cfg_pending, PHASE_INC, PAL_EN, CVBS, COLORBURST_RANGE,
              line_len, locked, chroma_kill};
         a = s; a.ack = 1'b0;
         b = prev; b.ack = 1'b0;
         if (first || s.ack || (a != b)) begin
            n_total++;
            if (q_tag.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_event cyc=%0d got=%h want=none", cyc, s);
            end else begin
               e  = q_snap.pop_front();
               ec = q_cyc.pop_front();
               et = q_tag.pop_front();
               if (s !== e) begin
                  n_bad++;
                  $display("FAIL %s cyc=%0d got=%h want=%h", et, cyc, s, e);
               end else begin
                  $display("chk %s cyc=%0d ok", et, cyc);
               end
               if (ec >= 0) begin
                  n_total++;
                  if (ec != cyc) begin
                     n_bad++;
                     $display("FAIL %s_cycle got=%0d want=%0d", et, cyc, ec);
                  end
               end
            end
         end
         prev  = s;
         first = 1'b0;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      m = reset_snap();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push_at("reset_state", -1);
      started = 1'b1;
      tick();

      // Phase increment write, commit, apply 50 clocks later on vsync.
      write(2'd0, 40'h12_3456_789A); push("wr_phase"); tick();
      write(2'd3, 40'hFF_FFFF_FFFF); m.pend = 1'b1; push("wr_commit"); tick();
      repeat (49) tick();
      vsync = 1'b1; m.phase = 40'h12_3456_789A; m.pend = 1'b0;
      push("apply_phase_on_vsync"); tick();
      repeat (3) tick();
      vsync = 1'b0; tick();

      // Lock acquisition: 1000-clock lines, lock on the 4th edge.
      hsync = 1'b1; last_hs = cyc; tick();
      hs_at(1000); tick();
      hs_at(1000); tick();
      hs_at(1000); m.lock = 1'b1; m.kill = 1'b0; m.llen = 12'd1000;
      push("lock_4th_edge"); tick();

      // Burst end 1020 applied while locked: clamps to line_len-1.
      tick();
      write(2'd2, {23'd0, 7'd50, 10'd1020}); push("wr_range"); tick();
      write(2'd3, 40'h0); m.pend = 1'b1; push("wr_commit_range"); tick();
      vsync = 1'b1; m.pend = 1'b0; m.range = {7'd50, 10'd999};
      push("apply_range_clamped"); tick();
      vsync = 1'b0; tick();
      hs_at(1000); tick();

      // One 1003-clock line unlocks; unclamped end shows 1020 again.
      hs_at(1003); m.lock = 1'b0; m.kill = 1'b1; m.range = {7'd50, 10'd1020};
      push("unlock_on_1003"); tick();
      // First 1000 period re-seeds the reference, two more matches relock.
      hs_at(1000); tick();
      hs_at(1000); tick();
      hs_at(1000); m.lock = 1'b1; m.kill = 1'b0; m.range = {7'd50, 10'd999};
      push("relock_1000"); tick();

      // Mode write on the vsync-edge cycle stays in shadow.
      write(2'd3, 40'h0); m.pend = 1'b1; push("wr_commit_pal"); tick();
      tick();
      vsync = 1'b1; write(2'd1, 40'h3); m.pend = 1'b0;
      push("mode_write_on_edge_old_applied"); tick();
      vsync = 1'b0; tick();
      write(2'd3, 40'h0); m.pend = 1'b1; push("wr_commit_pal2"); tick();
      vsync = 1'b1; m.pend = 1'b0; m.pal = 1'b1; m.cvbs = 1'b1;
      push("apply_new_mode"); tick();
      vsync = 1'b0; tick();

      // Commit on the vsync-edge cycle: applies now and stays armed.
      write(2'd0, 40'hAB_CDEF_0123); push("wr_phase2"); tick();
      write(2'd3, 40'h0); m.pend = 1'b1; push("wr_commit_phase2"); tick();
      tick();
      vsync = 1'b1; write(2'd3, 40'h0); m.phase = 40'hAB_CDEF_0123;
      push("commit_on_edge_stays_armed"); tick();
      vsync = 1'b0; tick();
      vsync = 1'b1; m.pend = 1'b0; push("apply_rearmed"); tick();
      vsync = 1'b0; tick();

      // hsync stops: unlock exactly TIMEOUT clocks after the last edge.
      hs_at(1000);
      m.lock = 1'b0; m.kill = 1'b1; m.range = {7'd50, 10'd1020};
      push_at("hsync_timeout", cyc + 1 + TIMEOUT); tick();
      while (cyc < last_hs + TIMEOUT + 20) tick();

      // Reset in the middle of an armed commit abandons it.
      write(2'd0, 40'h55_5555_5555); push("wr_phase3"); tick();
      write(2'd3, 40'h0); m.pend = 1'b1; push("wr_commit_phase3"); tick();
      #2;
      reset = 1'b1; m = reset_snap(); push("async_reset_mid_commit");
      repeat (3) tick();
      reset = 1'b0;
      tick();
      vsync = 1'b1; repeat (3) tick();
      vsync = 1'b0; tick();
      hsync = 1'b1; last_hs = cyc; tick();
      hs_at(1000); tick();
      hs_at(1000); tick();
      hs_at(1000); m.lock = 1'b1; m.kill = 1'b0; m.llen = 12'd1000;
      push("relock_after_reset"); tick();
      repeat (20) tick();

      while (q_tag.size() > 0) begin
         n_total++;
         n_bad++;
         $display("FAIL missing_%s got=no_event want_cycle=%0d", q_tag[0], q_cyc[0]);
         void'(q_tag.pop_front());
         void'(q_cyc.pop_front());
         void'(q_snap.pop_front());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
